// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM encodings, default instruction words and the IF/ID bundle.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN_DEF  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSN_DEF = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_unit_ifid.sv
// IF/ID pipeline register: 97-bit {ir, pc, pc4, valid}.
// Load wins over bubble; a bubble keeps pc/pc4 and clears ir/valid.
module ifid_pipe_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    // Capture, insert bubble, or hold
    always_ff @(posedge clk) begin
        if (reset) begin
            q.ir    <= NOP_INSN;
            q.pc    <= '0;
            q.pc4   <= '0;
            q.valid <= 1'b0;
        end else if (load) begin
            q <= d;
        end else if (bubble) begin
            q.ir    <= NOP_INSN;
            q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALT control, IF/ID capture.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN = HALT_INSN_DEF,
    parameter logic [31:0] NOP_INSN  = NOP_INSN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_pc,
    input  logic [31:0] im_ir,
    output logic [31:0] ifid_ir,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         load, bubble;
    logic         stall_cyc;
    if_id_t       ifid_d, ifid_q;

    // State and PC registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state, next PC and IF/ID controls; redirect > stall > normal
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        load      = 1'b0;
        bubble    = 1'b0;
        stall_cyc = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d   = redirect_pc & ~32'd3;
                    bubble = 1'b1;
                end else if (stall) begin
                    stall_cyc = 1'b1;
                end else begin
                    pc_d = pc_q + PC_INC;
                    if (flush) begin
                        bubble = 1'b1;
                    end else begin
                        load = 1'b1;
                        if (im_ir == HALT_INSN)
                            state_d = HALT;
                    end
                end
            end
            HALT: begin
                bubble = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_pc & ~32'd3;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign ifid_d.ir    = im_ir;
    assign ifid_d.pc    = pc_q;
    assign ifid_d.pc4   = pc_q + PC_INC;
    assign ifid_d.valid = 1'b1;

    ifid_pipe_reg #(
        .NOP_INSN (NOP_INSN)
    ) u_ifid (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .bubble (bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign im_pc      = pc_q;
    assign ifid_ir    = ifid_q.ir;
    assign ifid_pc    = ifid_q.pc;
    assign ifid_pc4   = ifid_q.pc4;
    assign ifid_valid = ifid_q.valid;
    assign halted     = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    // Count valid captures and stalled RUN cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_cyc)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    logic unused_stall_cyc;
    assign unused_stall_cyc = stall_cyc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: free-run loop plus a
// cycle-by-cycle vector table covering stall, flush, redirect, halt.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] im_pc;
    logic [31:0] im_ir;
    logic [31:0] ifid_ir;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] mem [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign im_ir = mem[im_pc[5:2]];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_pc          (im_pc),
        .im_ir          (im_ir),
        .ifid_ir        (ifid_ir),
        .ifid_pc        (ifid_pc),
        .ifid_pc4       (ifid_pc4),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] im_pc;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ir;
        logic        valid;
        logic        halted;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] w(int i);
        return 32'h0000_0645 | (32'(i) << 16);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(logic s, logic f, logic rv, logic [31:0] rpc,
                       logic [31:0] ipc, logic [31:0] pc, logic [31:0] pc4,
                       logic [31:0] ir, logic v, logic h);
        vec_t r;
        r.stall = s; r.flush = f; r.rv = rv; r.rpc = rpc;
        r.im_pc = ipc; r.pc = pc; r.pc4 = pc4;
        r.ir = ir; r.valid = v; r.halted = h;
        vecs.push_back(r);
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, " im_pc"}, im_pc, 32'h0);
        chk({tag, " ifid_ir"}, ifid_ir, 32'h0);
        chk({tag, " ifid_pc"}, ifid_pc, 32'h0);
        chk({tag, " ifid_pc4"}, ifid_pc4, 32'h0);
        chk({tag, " valid"}, 32'(ifid_valid), 32'h0);
        chk({tag, " halted"}, 32'(halted), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = w(i);
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        step();
        step();
        check_reset_state("reset");

        // Boot cycle then 20 free-running captures
        reset = 1'b0;
        step();
        chk("boot im_pc", im_pc, 32'h0);
        chk("boot valid", 32'(ifid_valid), 32'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("run%0d im_pc", i), im_pc, 32'(4 * (i + 1)));
            chk($sformatf("run%0d ifid_pc", i), ifid_pc, 32'(4 * i));
            chk($sformatf("run%0d ifid_pc4", i), ifid_pc4, 32'(4 * i + 4));
            chk($sformatf("run%0d ifid_ir", i), ifid_ir, w(i % 16));
            chk($sformatf("run%0d valid", i), 32'(ifid_valid), 32'h1);
        end

        // Place HALT at 0x1C while in reset
        reset = 1'b1;
        @(negedge clk);
        mem[7] = 32'hFFFF_FFFF;
        step();
        check_reset_state("reset2");
        reset = 1'b0;

        //  s  f  rv rpc          im_pc        pc           pc4          ir            v  h
        add(0, 0, 0, 32'h0,       32'h0,       32'h0,       32'h0,       32'h0,        0, 0);
        add(0, 0, 0, 32'h0,       32'h4,       32'h0,       32'h4,       w(0),         1, 0);
        add(0, 0, 0, 32'h0,       32'h8,       32'h4,       32'h8,       w(1),         1, 0);
        add(0, 0, 0, 32'h0,       32'hC,       32'h8,       32'hC,       w(2),         1, 0);
        add(0, 0, 0, 32'h0,       32'h10,      32'hC,       32'h10,      w(3),         1, 0);
        add(1, 0, 0, 32'h0,       32'h10,      32'hC,       32'h10,      w(3),         1, 0);
        add(1, 1, 0, 32'h0,       32'h10,      32'hC,       32'h10,      w(3),         1, 0);
        add(1, 0, 0, 32'h0,       32'h10,      32'hC,       32'h10,      w(3),         1, 0);
        add(0, 0, 0, 32'h0,       32'h14,      32'h10,      32'h14,      w(4),         1, 0);
        add(0, 1, 0, 32'h0,       32'h18,      32'h10,      32'h14,      32'h0,        0, 0);
        add(1, 0, 1, 32'h1F,      32'h1C,      32'h10,      32'h14,      32'h0,        0, 0);
        add(0, 0, 0, 32'h0,       32'h20,      32'h1C,      32'h20,      32'hFFFF_FFFF, 1, 1);
        add(0, 0, 0, 32'h0,       32'h20,      32'h1C,      32'h20,      32'h0,        0, 1);
        add(1, 0, 0, 32'h0,       32'h20,      32'h1C,      32'h20,      32'h0,        0, 1);
        add(0, 0, 1, 32'h0,       32'h0,       32'h1C,      32'h20,      32'h0,        0, 0);
        add(0, 0, 0, 32'h0,       32'h4,       32'h0,       32'h4,       w(0),         1, 0);
        add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,   32'h4,       32'h0,        0, 0);
        add(0, 0, 0, 32'h0,       32'h0,       32'hFFFF_FFFC, 32'h0,     w(15),        1, 0);
        add(0, 1, 1, 32'hA,       32'h8,       32'hFFFF_FFFC, 32'h0,     32'h0,        0, 0);
        add(0, 0, 0, 32'h0,       32'hC,       32'h8,       32'hC,       w(2),         1, 0);
        add(0, 0, 1, 32'h1C,      32'h1C,      32'h8,       32'hC,       32'h0,        0, 0);
        add(0, 1, 0, 32'h0,       32'h20,      32'h8,       32'hC,       32'h0,        0, 0);
        add(0, 0, 0, 32'h0,       32'h24,      32'h20,      32'h24,      w(8),         1, 0);

        foreach (vecs[i]) begin
            stall = vecs[i].stall;
            flush = vecs[i].flush;
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            step();
            chk($sformatf("vec%0d im_pc", i), im_pc, vecs[i].im_pc);
            chk($sformatf("vec%0d ifid_pc", i), ifid_pc, vecs[i].pc);
            chk($sformatf("vec%0d ifid_pc4", i), ifid_pc4, vecs[i].pc4);
            chk($sformatf("vec%0d ifid_ir", i), ifid_ir, vecs[i].ir);
            chk($sformatf("vec%0d valid", i), 32'(ifid_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].halted));
        end
        stall = 1'b0;
        flush = 1'b0;
        redirect_valid = 1'b0;

`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

        // Mid-operation reset clears everything
        step();
        reset = 1'b1;
        step();
        check_reset_state("midreset");
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_cnt clr", perf_fetch_cnt, 32'd0);
        chk("perf_stall_cnt clr", perf_stall_cnt, 32'd0);
`endif
        reset = 1'b0;
        step();
        step();
        chk("post reset ifid_ir", ifid_ir, w(0));
        chk("post reset valid", 32'(ifid_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
